config_rx_monitor: RTL and testbench
====================================

# config_rx_monitor

Fabric-side receiver and checker for the configuration load bus: the consuming end of the frame-data plus one-hot frame-enable stream that the bitstream loader drives into the `fpga` top.
- **Frame commit:** the block tracks the advancing one-hot enable and commits each frame as the enable leaves its bit, then presents the frame on a readback port.
- **Checking:** it checks ordering and, optionally, a CRC.
- **Release:** it raises `ff_en` a fixed delay after a clean load.
- **Placement:** it sits between the loader and the fabric's `ff_en`, replacing the free-running timed release in bench wrappers.

## Interface
Parameters:
- `CFG_W`, default 384: config frame data width.
- `CFG_N`, default 267: number of frames, which is also the enable width.
- `FF_EN_DLY`, default 20: cycles from `cfg_done` to `ff_en`. Legal range is 1..255.
- `IDX_W`, default `$clog2(CFG_N)`: frame index width.

Ports:
- `clock`, in, 1: the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `configs_in`, in, `CFG_W`: frame data from the loader.
- `configs_en`, in, `CFG_N`: one-hot frame enable from the loader.
- `exp_crc`, in, 32: expected CRC-32 of all frames. Only present with `CFG_RX_CRC_EN`.
- `frame_vld`, out, 1: one-cycle pulse; the frame was committed.
- `frame_idx`, out, `IDX_W`: index of the committed frame.
- `frame_data`, out, `CFG_W`: data of the committed frame.
- `cfg_done`, out, 1: sticky; all frames loaded cleanly.
- `cfg_err`, out, 1: sticky; a protocol or CRC error occurred.
- `err_code`, out, 2: error code. 0 = none, 1 = not one-hot, 2 = out-of-order, 3 = CRC mismatch.
- `ff_en`, out, 1: fabric flip-flop enable.

## Operation
States are IDLE, LOAD, DONE and ERR.

Internal registers:
- `en_q`: `configs_en` from the previous cycle.
- `data_q`: `configs_in` from the previous cycle.
- `exp_bit`: the next legal enable, kept as an index.

State transitions:
- **IDLE:**
  - `configs_en` == 0: stay in IDLE.
  - `configs_en` == bit 0: go to LOAD.
  - Any other value: go to ERR. The code is 1 if the value is not one-hot, otherwise 2.
- **LOAD, `configs_en` == `en_q`:** no commit; `data_q` keeps tracking the data.
- **LOAD, `configs_en` == `en_q << 1`, with `en_q` ≠ bit `CFG_N-1`:**
  - Commit `data_q` as frame k, where k is the index of `en_q`.
  - Stay in LOAD.
- **LOAD, `en_q` == bit `CFG_N-1` and `configs_en` == 0:**
  - Commit the last frame.
  - Go to DONE, or to ERR with code 3 if the CRC check is enabled and fails.
- **LOAD, any other change:** go to ERR. The code is 1 if the new value is nonzero and not one-hot, otherwise 2. This covers skips, backward moves and a premature zero.
- **DONE and ERR:** absorbing until `rst`. Enable activity in these states is ignored and produces no `frame_vld`.

Other rules:
- **Error priority:** not-one-hot takes priority over out-of-order.
- **`ff_en` counter:** an 8-bit counter starts on entry to DONE. `ff_en` rises when the count reaches `FF_EN_DLY`, then holds. `ff_en` never rises in ERR.
- **Degenerate frame count:** when `CFG_N` = 1, a transition from bit 0 to 0 commits frame 0 and goes to DONE.

## Timing
- **Reset:** at the `rst` edge all outputs are 0, the state is IDLE, `en_q` = 0, `data_q` = 0 and the CRC is 0xFFFFFFFF. This also applies when `rst` arrives mid-LOAD: no partial commit is output.
- **Commit latency:** `frame_vld`, `frame_idx` and `frame_data` are registered. They update at the same edge that first samples the new `configs_en` value, and are valid for exactly one cycle.
- **Committed data:** the committed data is the last `configs_in` value presented while the old enable bit was high.
- **Flags:** `cfg_done`, `cfg_err` and `err_code` update on the same edge as the final commit or the error detection.
- **`ff_en` edge:** `ff_en` rises `FF_EN_DLY` cycles after the `cfg_done` edge.
- **Hold time:** the loader may hold an enable bit for any number of cycles of at least 1.

## Configuration
- **With `CFG_RX_CRC_EN` defined:**
  - A CRC-32 (poly 0x04C11DB7, init all-ones, final XOR all-ones, frame bit 0 first) is folded over every committed frame in a single cycle.
  - The `exp_crc` port exists.
  - On the final commit, if the CRC differs from `exp_crc`, the block goes to ERR with code 3.
- **Without `CFG_RX_CRC_EN`:**
  - The CRC logic and the `exp_crc` port are absent.
  - A clean final commit always goes to DONE.
  - Code 3 is unreachable.

## Structure
- **Shared package `cfg_pkg`:**
  - State enum `cfg_rx_state_t`.
  - `err_code` localparams `CFG_ERR_NONE`, `CFG_ERR_ONEHOT`, `CFG_ERR_ORDER` and `CFG_ERR_CRC`.
  - `CFG_CRC_POLY` and `CFG_CRC_INIT`.
- **Sub-module `cfg_crc32_frame`:** purely combinational, with inputs `crc_in[31:0]` and `data[CFG_W-1:0]`, and output `crc_out[31:0]`. It is instantiated only under `CFG_RX_CRC_EN`.

## Test plan
All scenarios use `CFG_N`=4 and `CFG_W`=8, with `FF_EN_DLY`=5 unless stated otherwise.
- **Clean load:** drive enable 0001, 0010, 0100, 1000, 0000 with data A5, 3C, 0F, F0, each held 2 cycles.
  - Four `frame_vld` pulses, idx 0..3, with data A5, 3C, 0F, F0.
  - `cfg_done`=1 and `ff_en`=1 five cycles later.
- **Data change within a hold:** hold enable 0001 for 3 cycles with data 11, 22, 33.
  - Frame 0 commits as 33.
- **Skip:** drive enable 0001 then 0100.
  - `cfg_err`=1 and `err_code`=2.
  - No further `frame_vld` pulses, and `ff_en` stays 0.
- **Not one-hot:** drive enable 0001 then 0110.
  - `err_code`=1.
- **Reset mid-operation:** assert `rst` for one cycle after frame 1 commits, then run the clean load again.
  - Frame indices restart at 0, and `cfg_done` is reached.
- **CRC (`CFG_RX_CRC_EN`):** run the clean load with `exp_crc` set to the correct value, then repeat with that value XOR 1.
  - Correct value: `cfg_done`=1.
  - Wrong value: `cfg_err`=1, `err_code`=3, and `ff_en` stays 0.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared types and constants for the configuration load bus receiver.
package cfg_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2,
        StErr  = 2'd3
    } cfg_rx_state_t;

    localparam logic [1:0] CFG_ERR_NONE   = 2'd0;
    localparam logic [1:0] CFG_ERR_ONEHOT = 2'd1;
    localparam logic [1:0] CFG_ERR_ORDER  = 2'd2;
    localparam logic [1:0] CFG_ERR_CRC    = 2'd3;

    localparam logic [31:0] CFG_CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CFG_CRC_INIT = 32'hFFFF_FFFF;

endpackage

// File: rtl/cfg_crc32_frame.sv
// Combinational CRC-32 fold of one whole config frame, frame bit 0 shifted in first.
module cfg_crc32_frame
    import cfg_pkg::*;
#(
    parameter int unsigned CFG_W = 384
) (
    input  logic [31:0]      crc_in,
    input  logic [CFG_W-1:0] data,
    output logic [31:0]      crc_out
);

    logic [31:0] crc_c;

    always_comb begin
        crc_c = crc_in;
        for (int i = 0; i < int'(CFG_W); i++) begin
            crc_c = {crc_c[30:0], 1'b0} ^ ((crc_c[31] ^ data[i]) ? CFG_CRC_POLY : 32'h0);
        end
    end

    assign crc_out = crc_c;

endmodule

// File: rtl/config_rx_monitor.sv
// Receiver/checker for the one-hot frame-enable config bus; releases ff_en after a clean load.
// Optional CRC-32 check of all committed frames is enabled with `define CFG_RX_CRC_EN.
module config_rx_monitor
    import cfg_pkg::*;
#(
    parameter int unsigned CFG_W     = 384,
    parameter int unsigned CFG_N     = 267,
    parameter int unsigned FF_EN_DLY = 20,
    parameter int unsigned IDX_W     = (CFG_N > 1) ? $clog2(CFG_N) : 1
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [CFG_W-1:0] configs_in,
    input  logic [CFG_N-1:0] configs_en,
`ifdef CFG_RX_CRC_EN
    input  logic [31:0]      exp_crc,
`endif
    output logic             frame_vld,
    output logic [IDX_W-1:0] frame_idx,
    output logic [CFG_W-1:0] frame_data,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [1:0]       err_code,
    output logic             ff_en
);

    localparam logic [CFG_N-1:0] EnFirst = CFG_N'(1);
    localparam logic [7:0]       DlyCnt  = 8'(FF_EN_DLY);

    cfg_rx_state_t    state_q, state_d;
    logic [CFG_N-1:0] en_q, en_d;
    logic [CFG_W-1:0] data_q, data_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             frame_vld_q, frame_vld_d;
    logic [IDX_W-1:0] frame_idx_q, frame_idx_d;
    logic [CFG_W-1:0] frame_data_q, frame_data_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic             ff_en_q, ff_en_d;
    logic             commit;
    logic             en_onehot;

    assign en_onehot = (configs_en != '0) && ((configs_en & (configs_en - CFG_N'(1))) == '0);

`ifdef CFG_RX_CRC_EN
    logic [31:0] crc_q, crc_d, crc_next;

    cfg_crc32_frame #(
        .CFG_W (CFG_W)
    ) u_crc (
        .crc_in  (crc_q),
        .data    (data_q),
        .crc_out (crc_next)
    );
`endif

    always_comb begin
        state_d      = state_q;
        en_d         = configs_en;
        data_d       = configs_in;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        frame_vld_d  = 1'b0;
        frame_idx_d  = frame_idx_q;
        frame_data_d = frame_data_q;
        done_d       = done_q;
        err_d        = err_q;
        code_d       = code_q;
        ff_en_d      = ff_en_q;
        commit       = 1'b0;
`ifdef CFG_RX_CRC_EN
        crc_d        = crc_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (configs_en == EnFirst) begin
                    state_d = StLoad;
                    idx_d   = '0;
                end else if (configs_en != '0) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                    code_d  = en_onehot ? CFG_ERR_ORDER : CFG_ERR_ONEHOT;
                end
            end
            StLoad: begin
                if (configs_en != en_q) begin
                    if (en_q[CFG_N-1] && (configs_en == '0)) begin
                        commit = 1'b1;
                        cnt_d  = '0;
`ifdef CFG_RX_CRC_EN
                        if (~crc_next != exp_crc) begin
                            state_d = StErr;
                            err_d   = 1'b1;
                            code_d  = CFG_ERR_CRC;
                        end else begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end
`else
                        state_d = StDone;
                        done_d  = 1'b1;
`endif
                    end else if (!en_q[CFG_N-1] && (configs_en == (en_q << 1))) begin
                        commit = 1'b1;
                        idx_d  = idx_q + IDX_W'(1);
                    end else begin
                        // Skips, backward moves and premature zero all count as ordering faults
                        state_d = StErr;
                        err_d   = 1'b1;
                        code_d  = ((configs_en != '0) && !en_onehot) ? CFG_ERR_ONEHOT
                                                                     : CFG_ERR_ORDER;
                    end
                end
            end
            StDone: begin
                if (!ff_en_q) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == DlyCnt) begin
                        ff_en_d = 1'b1;
                    end
                end
            end
            StErr: begin
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (commit) begin
            frame_vld_d  = 1'b1;
            frame_idx_d  = idx_q;
            frame_data_d = data_q;
`ifdef CFG_RX_CRC_EN
            crc_d        = crc_next;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q      <= StIdle;
            en_q         <= '0;
            data_q       <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            frame_vld_q  <= 1'b0;
            frame_idx_q  <= '0;
            frame_data_q <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            code_q       <= CFG_ERR_NONE;
            ff_en_q      <= 1'b0;
`ifdef CFG_RX_CRC_EN
            crc_q        <= CFG_CRC_INIT;
`endif
        end else begin
            state_q      <= state_d;
            en_q         <= en_d;
            data_q       <= data_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            frame_vld_q  <= frame_vld_d;
            frame_idx_q  <= frame_idx_d;
            frame_data_q <= frame_data_d;
            done_q       <= done_d;
            err_q        <= err_d;
            code_q       <= code_d;
            ff_en_q      <= ff_en_d;
`ifdef CFG_RX_CRC_EN
            crc_q        <= crc_d;
`endif
        end
    end

    assign frame_vld  = frame_vld_q;
    assign frame_idx  = frame_idx_q;
    assign frame_data = frame_data_q;
    assign cfg_done   = done_q;
    assign cfg_err    = err_q;
    assign err_code   = code_q;
    assign ff_en      = ff_en_q;

endmodule

// File: tb/tb_config_rx_monitor.sv
// Scoreboard bench for config_rx_monitor with CFG_N=4, CFG_W=8, FF_EN_DLY=5.
module tb_config_rx_monitor;

    localparam int unsigned CFG_W = 8;
    localparam int unsigned CFG_N = 4;
    localparam int unsigned DLY   = 5;
    localparam int unsigned IDX_W = 2;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [CFG_W-1:0] data;
    } frame_t;

    logic             clock = 1'b0;
    logic             rst   = 1'b1;
    logic [CFG_W-1:0] configs_in = '0;
    logic [CFG_N-1:0] configs_en = '0;
    logic             frame_vld;
    logic [IDX_W-1:0] frame_idx;
    logic [CFG_W-1:0] frame_data;
    logic             cfg_done;
    logic             cfg_err;
    logic [1:0]       err_code;
    logic             ff_en;
`ifdef CFG_RX_CRC_EN
    logic [31:0]      exp_crc = '0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    frame_t exp_q[$];

    config_rx_monitor #(
        .CFG_W     (CFG_W),
        .CFG_N     (CFG_N),
        .FF_EN_DLY (DLY),
        .IDX_W     (IDX_W)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .configs_in (configs_in),
        .configs_en (configs_en),
`ifdef CFG_RX_CRC_EN
        .exp_crc    (exp_crc),
`endif
        .frame_vld  (frame_vld),
        .frame_idx  (frame_idx),
        .frame_data (frame_data),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .err_code   (err_code),
        .ff_en      (ff_en)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every frame_vld pulse must match the head of the expected queue
    always @(negedge clock) begin
        if (frame_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_frame: got idx %0d data %0h expected no pulse",
                         frame_idx, frame_data);
            end else begin
                frame_t f;
                f = exp_q.pop_front();
                check("frame_idx", 32'(frame_idx), 32'(f.idx));
                check("frame_data", 32'(frame_data), 32'(f.data));
            end
        end
    end

    task automatic drive(input logic [CFG_N-1:0] en, input logic [CFG_W-1:0] d, input int n);
        configs_en = en;
        configs_in = d;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        configs_en = '0;
        configs_in = '0;
        @(posedge clock);
        #1;
        rst = 1'b0;
    endtask

    task automatic push(input logic [IDX_W-1:0] i, input logic [CFG_W-1:0] d);
        exp_q.push_back('{idx: i, data: d});
    endtask

    task automatic drain_check(input string name);
        @(negedge clock);
        #1;
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic status(input string name, input logic done, input logic err,
                          input logic [1:0] code);
        check({name, "_done"}, 32'(cfg_done), 32'(done));
        check({name, "_err"}, 32'(cfg_err), 32'(err));
        check({name, "_code"}, 32'(err_code), 32'(code));
    endtask

    task automatic clean_load();
        push(2'd0, 8'hA5);
        push(2'd1, 8'h3C);
        push(2'd2, 8'h0F);
        push(2'd3, 8'hF0);
        drive(4'b0001, 8'hA5, 2);
        drive(4'b0010, 8'h3C, 2);
        drive(4'b0100, 8'h0F, 2);
        drive(4'b1000, 8'hF0, 2);
        drive(4'b0000, 8'h00, 1);
    endtask

    task automatic ff_en_stays_low(input string name);
        repeat (12) @(posedge clock);
        #1;
        check(name, 32'(ff_en), 32'd0);
    endtask

`ifdef CFG_RX_CRC_EN
    function automatic logic [31:0] ref_crc();
        logic [7:0]  fr [4];
        logic [31:0] c;
        fr[0] = 8'hA5;
        fr[1] = 8'h3C;
        fr[2] = 8'h0F;
        fr[3] = 8'hF0;
        c = 32'hFFFF_FFFF;
        for (int f = 0; f < 4; f++) begin
            for (int b = 0; b < 8; b++) begin
                if (c[31] ^ fr[f][b]) c = (c << 1) ^ 32'h04C1_1DB7;
                else                   c = c << 1;
            end
        end
        return ~c;
    endfunction
`endif

    initial begin
        do_reset();
        check("rst_vld", 32'(frame_vld), 32'd0);
        check("rst_ff_en", 32'(ff_en), 32'd0);
        status("rst", 1'b0, 1'b0, 2'd0);

        // Clean load, then ff_en exactly DLY edges after cfg_done
        clean_load();
        status("clean", 1'b1, 1'b0, 2'd0);
        check("clean_ff_en_at_done", 32'(ff_en), 32'd0);
        repeat (DLY - 1) @(posedge clock);
        #1;
        check("clean_ff_en_early", 32'(ff_en), 32'd0);
        @(posedge clock);
        #1;
        check("clean_ff_en_on_time", 32'(ff_en), 32'd1);
        drive(4'b0001, 8'h77, 3);
        check("done_absorbing", 32'(cfg_done), 32'd1);
        drain_check("clean_queue");

        // Data changes within a hold; later frames held only one cycle
        do_reset();
        push(2'd0, 8'h33);
        push(2'd1, 8'h44);
        push(2'd2, 8'h55);
        push(2'd3, 8'h66);
        drive(4'b0001, 8'h11, 1);
        drive(4'b0001, 8'h22, 1);
        drive(4'b0001, 8'h33, 1);
        drive(4'b0010, 8'h44, 1);
        drive(4'b0100, 8'h55, 1);
        drive(4'b1000, 8'h66, 1);
        drive(4'b0000, 8'h00, 1);
        status("hold", 1'b1, 1'b0, 2'd0);
        drain_check("hold_queue");

        // Skip: no commit, no further pulses, ff_en stays low
        do_reset();
        drive(4'b0001, 8'hAA, 2);
        drive(4'b0100, 8'hBB, 1);
        status("skip", 1'b0, 1'b1, 2'd2);
        drive(4'b1000, 8'hCC, 2);
        drive(4'b0000, 8'h00, 2);
        ff_en_stays_low("skip_ff_en");
        drain_check("skip_queue");

        // Not one-hot during load
        do_reset();
        drive(4'b0001, 8'h01, 2);
        drive(4'b0110, 8'h02, 1);
        status("onehot", 1'b0, 1'b1, 2'd1);
        drain_check("onehot_queue");

        // Errors straight from idle
        do_reset();
        drive(4'b0010, 8'h00, 1);
        status("idle_order", 1'b0, 1'b1, 2'd2);
        do_reset();
        drive(4'b0011, 8'h00, 1);
        status("idle_onehot", 1'b0, 1'b1, 2'd1);

        // Premature zero after frame 0 commits
        do_reset();
        push(2'd0, 8'h5A);
        drive(4'b0001, 8'h5A, 2);
        drive(4'b0010, 8'h6B, 2);
        drive(4'b0000, 8'h00, 1);
        status("prem_zero", 1'b0, 1'b1, 2'd2);
        drain_check("prem_queue");

        // Backward move
        do_reset();
        push(2'd0, 8'h12);
        drive(4'b0001, 8'h12, 1);
        drive(4'b0010, 8'h34, 1);
        drive(4'b0001, 8'h56, 1);
        status("backward", 1'b0, 1'b1, 2'd2);
        drain_check("back_queue");

        // Reset mid-load after frame 1 commits, then a full clean load
        do_reset();
        push(2'd0, 8'hA5);
        push(2'd1, 8'h3C);
        drive(4'b0001, 8'hA5, 2);
        drive(4'b0010, 8'h3C, 2);
        drive(4'b0100, 8'h0F, 1);
        drain_check("mid_pre_queue");
        rst = 1'b1;
        @(posedge clock);
        #1;
        check("mid_rst_vld", 32'(frame_vld), 32'd0);
        status("mid_rst", 1'b0, 1'b0, 2'd0);
        rst        = 1'b0;
        configs_en = '0;
        @(posedge clock);
        #1;
        clean_load();
        status("mid_reload", 1'b1, 1'b0, 2'd0);
        drain_check("mid_queue");

`ifdef CFG_RX_CRC_EN
        do_reset();
        exp_crc = ref_crc();
        clean_load();
        status("crc_ok", 1'b1, 1'b0, 2'd0);
        drain_check("crc_ok_queue");
        do_reset();
        exp_crc = ref_crc() ^ 32'h1;
        clean_load();
        status("crc_bad", 1'b0, 1'b1, 2'd3);
        ff_en_stays_low("crc_bad_ff_en");
        drain_check("crc_bad_queue");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
